// File: rtl/hdmi_infoframe_pkg.sv
// Shared constants, FSM encoding and AVI field layout for InfoFrame receive parsers.
package hdmi_infoframe_pkg;

    localparam logic [7:0]  AVI_TYPE     = 8'h82;
    localparam int unsigned PACKET_BYTES = 28;
    localparam int unsigned HEADER_BYTES = 3;
    localparam logic [4:0]  LAST_PB      = 5'(PACKET_BYTES - 1);
    localparam logic [1:0]  LAST_HB      = 2'(HEADER_BYTES - 1);

    // Offsets of PB1..PB13 inside the shadow byte array (PB0 is not stored).
    localparam int unsigned SHADOW_BYTES = 13;
    localparam int unsigned PB1_OFS  = 0;
    localparam int unsigned PB2_OFS  = 1;
    localparam int unsigned PB3_OFS  = 2;
    localparam int unsigned PB4_OFS  = 3;
    localparam int unsigned PB5_OFS  = 4;
    localparam int unsigned PB6_OFS  = 5;
    localparam int unsigned PB7_OFS  = 6;
    localparam int unsigned PB8_OFS  = 7;
    localparam int unsigned PB9_OFS  = 8;
    localparam int unsigned PB10_OFS = 9;
    localparam int unsigned PB11_OFS = 10;
    localparam int unsigned PB12_OFS = 11;
    localparam int unsigned PB13_OFS = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2
    } parse_state_t;

    typedef struct packed {
        logic [1:0]  video_format;
        logic        active_format_present;
        logic [1:0]  bar_info;
        logic [1:0]  scan_info;
        logic [1:0]  colorimetry;
        logic [1:0]  picture_aspect_ratio;
        logic [3:0]  active_format_aspect_ratio;
        logic        it_content;
        logic [2:0]  extended_colorimetry;
        logic [1:0]  rgb_quantization_range;
        logic [1:0]  non_uniform_picture_scaling;
        logic [6:0]  video_id_code;
        logic [1:0]  ycc_quantization_range;
        logic [1:0]  content_type;
        logic [3:0]  pixel_repetition;
        logic [15:0] top_bar_end;
        logic [15:0] bottom_bar_start;
        logic [15:0] left_bar_end;
        logic [15:0] right_bar_start;
    } avi_fields_t;

    // Published values before any good frame: "same as picture" active format.
    function automatic avi_fields_t avi_fields_reset();
        avi_fields_t f;
        f = '0;
        f.active_format_aspect_ratio = 4'b1000;
        return f;
    endfunction

    // Map captured PB1..PB13 onto the decoded AVI fields.
    function automatic avi_fields_t decode_avi(input logic [SHADOW_BYTES-1:0][7:0] pb);
        avi_fields_t f;
        f.video_format                = pb[PB1_OFS][6:5];
        f.active_format_present       = pb[PB1_OFS][4];
        f.bar_info                    = pb[PB1_OFS][3:2];
        f.scan_info                   = pb[PB1_OFS][1:0];
        f.colorimetry                 = pb[PB2_OFS][7:6];
        f.picture_aspect_ratio        = pb[PB2_OFS][5:4];
        f.active_format_aspect_ratio  = pb[PB2_OFS][3:0];
        f.it_content                  = pb[PB3_OFS][7];
        f.extended_colorimetry        = pb[PB3_OFS][6:4];
        f.rgb_quantization_range      = pb[PB3_OFS][3:2];
        f.non_uniform_picture_scaling = pb[PB3_OFS][1:0];
        f.video_id_code               = pb[PB4_OFS][6:0];
        f.ycc_quantization_range      = pb[PB5_OFS][7:6];
        f.content_type                = pb[PB5_OFS][5:4];
        f.pixel_repetition            = pb[PB5_OFS][3:0];
        f.top_bar_end                 = {pb[PB7_OFS],  pb[PB6_OFS]};
        f.bottom_bar_start            = {pb[PB9_OFS],  pb[PB8_OFS]};
        f.left_bar_end                = {pb[PB11_OFS], pb[PB10_OFS]};
        f.right_bar_start             = {pb[PB13_OFS], pb[PB12_OFS]};
        return f;
    endfunction

endpackage

// File: rtl/infoframe_checksum_accum.sv
// Mod-256 running byte sum; zero_c reports whether the sum including this cycle's byte is zero.
module infoframe_checksum_accum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] din,
    output logic       zero_c
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // Clear takes effect before the add so a packet's first byte can seed the sum.
    always_comb begin
        sum_d = clear ? 8'h00 : sum_q;
        if (add_en) begin
            sum_d = sum_d + din;
        end
    end

    // Sum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign zero_c = (sum_d == 8'h00);

endmodule

// File: rtl/avi_info_frame_parser.sv
// Filters AVI InfoFrames from a byte-serial data-island stream and publishes validated fields atomically.
module avi_info_frame_parser
    import hdmi_infoframe_pkg::*;
#(
    parameter logic [7:0] EXPECTED_VERSION = 8'd2,
    parameter logic [4:0] MIN_LENGTH       = 5'd13
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic [7:0]  in_byte,
    output logic        frame_strobe,
    output logic        avi_valid,
    output logic [1:0]  video_format,
    output logic        active_format_present,
    output logic [1:0]  bar_info,
    output logic [1:0]  scan_info,
    output logic [1:0]  colorimetry,
    output logic [1:0]  picture_aspect_ratio,
    output logic [3:0]  active_format_aspect_ratio,
    output logic        it_content,
    output logic [2:0]  extended_colorimetry,
    output logic [1:0]  rgb_quantization_range,
    output logic [1:0]  non_uniform_picture_scaling,
    output logic [6:0]  video_id_code,
    output logic [1:0]  ycc_quantization_range,
    output logic [1:0]  content_type,
    output logic [3:0]  pixel_repetition,
    output logic [15:0] top_bar_end,
    output logic [15:0] bottom_bar_start,
    output logic [15:0] left_bar_end,
    output logic [15:0] right_bar_start,
    output logic        err_header,
    output logic        err_checksum,
    output logic        err_truncated
);

    parse_state_t state_q, state_d;

    logic [1:0]  hdr_idx_q;
    logic [4:0]  pb_idx_q;
    logic [4:0]  len_q;
    logic        is_avi_q;
    logic        hdr_bad_q;
    logic [SHADOW_BYTES-1:0][7:0] shadow_q;
    avi_fields_t fields_q;

    logic acc_clear_c;
    logic acc_add_c;
    logic acc_zero_c;
    logic start_pkt_c;
    logic trunc_c;
    logic last_byte_c;

    infoframe_checksum_accum u_accum (
        .clk    (clk_pixel),
        .reset  (reset),
        .clear  (acc_clear_c),
        .add_en (acc_add_c),
        .din    (in_byte),
        .zero_c (acc_zero_c)
    );

    // State register.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-byte control; in_sop always restarts a packet, from any state.
    always_comb begin
        state_d     = state_q;
        acc_clear_c = 1'b0;
        acc_add_c   = 1'b0;
        start_pkt_c = 1'b0;
        trunc_c     = 1'b0;
        last_byte_c = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                start_pkt_c = 1'b1;
                acc_clear_c = 1'b1;
                acc_add_c   = 1'b1;
                trunc_c     = (state_q != IDLE) && is_avi_q;
                state_d     = HEADER;
            end else begin
                unique case (state_q)
                    IDLE: state_d = IDLE;
                    HEADER: begin
                        acc_add_c = 1'b1;
                        if (hdr_idx_q == LAST_HB) begin
                            state_d = BODY;
                        end
                    end
                    BODY: begin
                        acc_add_c = (pb_idx_q <= len_q);
                        if (pb_idx_q == LAST_PB) begin
                            last_byte_c = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Header checks, byte indices, shadow capture and the completion verdict.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hdr_idx_q     <= 2'd0;
            pb_idx_q      <= 5'd0;
            len_q         <= 5'd0;
            is_avi_q      <= 1'b0;
            hdr_bad_q     <= 1'b0;
            shadow_q      <= '0;
            fields_q      <= avi_fields_reset();
            frame_strobe  <= 1'b0;
            avi_valid     <= 1'b0;
            err_header    <= 1'b0;
            err_checksum  <= 1'b0;
            err_truncated <= 1'b0;
        end else begin
            frame_strobe  <= 1'b0;
            err_header    <= 1'b0;
            err_checksum  <= 1'b0;
            err_truncated <= trunc_c;

            if (start_pkt_c) begin
                is_avi_q  <= (in_byte == AVI_TYPE);
                hdr_idx_q <= 2'd1;
                hdr_bad_q <= 1'b0;
                pb_idx_q  <= 5'd0;
                len_q     <= 5'd0;
            end else if (in_valid && state_q == HEADER) begin
                if (hdr_idx_q != LAST_HB) begin
                    if (is_avi_q && in_byte != EXPECTED_VERSION) begin
                        hdr_bad_q <= 1'b1;
                    end
                    hdr_idx_q <= hdr_idx_q + 2'd1;
                end else begin
                    len_q <= in_byte[4:0];
                    if (is_avi_q && (in_byte[7:5] != 3'd0 || in_byte[4:0] < MIN_LENGTH
                                     || in_byte[4:0] > LAST_PB)) begin
                        hdr_bad_q <= 1'b1;
                    end
                end
            end else if (in_valid && state_q == BODY) begin
                for (int unsigned i = 0; i < SHADOW_BYTES; i++) begin
                    if (pb_idx_q == 5'(i + 1)) begin
                        shadow_q[i] <= in_byte;
                    end
                end
                if (pb_idx_q != LAST_PB) begin
                    pb_idx_q <= pb_idx_q + 5'd1;
                end
            end

            // Shadow and flags still hold this frame's values even if a new HB0 arrives now.
            if (last_byte_c && is_avi_q) begin
                if (hdr_bad_q) begin
                    err_header <= 1'b1;
                end else if (!acc_zero_c) begin
                    err_checksum <= 1'b1;
                end else begin
                    fields_q     <= decode_avi(shadow_q);
                    frame_strobe <= 1'b1;
                    avi_valid    <= 1'b1;
                end
            end
        end
    end

    assign video_format                = fields_q.video_format;
    assign active_format_present       = fields_q.active_format_present;
    assign bar_info                    = fields_q.bar_info;
    assign scan_info                   = fields_q.scan_info;
    assign colorimetry                 = fields_q.colorimetry;
    assign picture_aspect_ratio        = fields_q.picture_aspect_ratio;
    assign active_format_aspect_ratio  = fields_q.active_format_aspect_ratio;
    assign it_content                  = fields_q.it_content;
    assign extended_colorimetry        = fields_q.extended_colorimetry;
    assign rgb_quantization_range      = fields_q.rgb_quantization_range;
    assign non_uniform_picture_scaling = fields_q.non_uniform_picture_scaling;
    assign video_id_code               = fields_q.video_id_code;
    assign ycc_quantization_range      = fields_q.ycc_quantization_range;
    assign content_type                = fields_q.content_type;
    assign pixel_repetition            = fields_q.pixel_repetition;
    assign top_bar_end                 = fields_q.top_bar_end;
    assign bottom_bar_start            = fields_q.bottom_bar_start;
    assign left_bar_end                = fields_q.left_bar_end;
    assign right_bar_start             = fields_q.right_bar_start;

endmodule

// File: doc/avi_info_frame_parser.md
Name: avi_info_frame_parser

Overview:
Receive-side counterpart of the AVI InfoFrame packet builder. It consumes a byte-serial HDMI data-island packet stream (HB0..HB2, then PB0..PB27) that an upstream packet deframer has recovered, and filters for AVI InfoFrames (type 0x82). It verifies version, length and checksum, then atomically publishes the decoded AVI fields to video-pipeline consumers such as the colorspace, aspect and pixel-repetition logic.

Parameters:
EXPECTED_VERSION, 8'd2, required HB1 value; any other value is a header error
MIN_LENGTH, 5'd13, smallest accepted HB2[4:0]; accepted range is MIN_LENGTH..27

Ports:
clk_pixel  in  1  pixel clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  in_byte is valid this cycle
in_sop  in  1  qualifies in_byte as HB0; only meaningful when in_valid=1
in_byte  in  8  packet byte, header first, then PB0..PB27
frame_strobe  out  1  1-cycle pulse: a new good AVI frame has been published
avi_valid  out  1  sticky; set on the first good frame, cleared only by reset
video_format  out  2  PB1[6:5]
active_format_present  out  1  PB1[4]
bar_info  out  2  PB1[3:2]
scan_info  out  2  PB1[1:0]
colorimetry  out  2  PB2[7:6]
picture_aspect_ratio  out  2  PB2[5:4]
active_format_aspect_ratio  out  4  PB2[3:0]
it_content  out  1  PB3[7]
extended_colorimetry  out  3  PB3[6:4]
rgb_quantization_range  out  2  PB3[3:2]
non_uniform_picture_scaling  out  2  PB3[1:0]
video_id_code  out  7  PB4[6:0]
ycc_quantization_range  out  2  PB5[7:6]
content_type  out  2  PB5[5:4]
pixel_repetition  out  4  PB5[3:0]
top_bar_end  out  16  {PB7,PB6}
bottom_bar_start  out  16  {PB9,PB8}
left_bar_end  out  16  {PB11,PB10}
right_bar_start  out  16  {PB13,PB12}
err_header  out  1  pulse: AVI type but bad version, length, or HB2[7:5]!=0
err_checksum  out  1  pulse: checksum failure
err_truncated  out  1  pulse: in_sop arrived mid-packet

Behaviour:
- Reset: all outputs are 0, except active_format_aspect_ratio=4'b1000. The FSM goes to IDLE and the byte index and accumulator clear.
- Byte acceptance: a byte is accepted only when in_valid=1. Idle gaps of any length between bytes are legal.
- IDLE: an accepted byte with in_sop=1 clears the accumulator, adds the byte, latches is_avi=(byte==8'h82), and goes to HEADER with index=1. Bytes without in_sop are dropped.
- HEADER: accepts HB1 and HB2 and adds both. HB1 must equal EXPECTED_VERSION. HB2[7:5] must be 0 and HB2[4:0] must lie in MIN_LENGTH..27, latched as len. Any violation while is_avi=1 sets the pending error hdr_bad. After HB2 the FSM goes to BODY with pb_idx=0.
- BODY: accepts PB0..PB27. Bytes with pb_idx<=len are added to the 8-bit mod-256 accumulator; later bytes are consumed but not summed. PB1..PB13 are captured into shadow registers.
- Completion: on acceptance of PB27 the FSM returns to IDLE. On the next cycle exactly one of the following happens, or nothing:
  - is_avi=0: silent, no output change.
  - hdr_bad: err_header pulses.
  - accumulator!=0: err_checksum pulses.
  - otherwise: the shadow registers copy to the outputs in the same edge, frame_strobe pulses and avi_valid is set.
- Latency: outputs are updated 1 cycle after PB27 is accepted.
- Outputs never change partially. A failed or aborted frame leaves the previous good values intact.
- in_sop while in HEADER or BODY: err_truncated pulses if is_avi=1. The current packet is discarded and the byte starts a new packet as HB0, with no dead cycle.
- Simultaneous events: a completion pulse for frame N and the HB0 of frame N+1 may occur in the same cycle; both must be handled.
- Index counters saturate and never wrap; the FSM forces return to IDLE at PB27.
- Reset asserted mid-packet aborts it with no error pulse.

Decomposition:
- Package hdmi_infoframe_pkg holds:
  - localparams AVI_TYPE=8'h82, PACKET_BYTES=28, HEADER_BYTES=3
  - byte-offset constants for PB1..PB13
  - FSM state encoding {IDLE, HEADER, BODY}
- Sub-module infoframe_checksum_accum: 8-bit mod-256 running sum with clear and add_en, and a zero flag. It is reusable by future Audio/SPD InfoFrame parsers.

Test Plan:
- Default frame: HB=82 02 0D, PB0=63, PB2=08, PB4=04, all other bytes 00 -> frame_strobe 1 cycle after PB27, video_id_code=4, active_format_aspect_ratio=8, avi_valid=1, bars all 0.
- Bar frame: HB=82 02 0D, PB0=5B, PB1=0C, PB2=08, PB4=04, PB6=PB7=PB10=PB11=FF, others 00 -> bar_info=3, top_bar_end=FFFF, bottom_bar_start=0000, left_bar_end=FFFF, right_bar_start=0000.
- Corrupt PB0 to 64 in the default frame -> err_checksum pulse, no frame_strobe, outputs keep their prior values.
- HB0=84 (Audio InfoFrame) with any body -> no pulses, outputs unchanged. HB1=01 on an AVI frame -> err_header only.
- in_sop at PB10 of an AVI frame, followed by a complete default frame -> err_truncated once, then a good frame_strobe. Repeat with random in_valid gaps; the result must be the same.
- Assert reset at PB5 of a frame -> all outputs return to reset values, no pulses, and the next good frame decodes normally.
